// File: rtl/l2_switch_fabric.sv
// N-port layer-2 switching core: round-robin accept, learn/lookup stage, registered egress.
// Optional entry aging is compiled in with `define L2SW_AGING_EN.
module l2_switch_fabric #(
    parameter int N_PORTS     = 4,
    parameter int ADDR_W      = 4,
    parameter int PAYLOAD_W   = 4,
    parameter int TABLE_DEPTH = 4,
    parameter int AGE_PERIOD  = 1024
) (
    input  logic                                       FPGA_CLK,
    input  logic                                       FPGA_RST_BTN,
    input  logic [N_PORTS-1:0]                         in_valid,
    input  logic [N_PORTS*(2*ADDR_W+PAYLOAD_W)-1:0]    in_frame,
    output logic [N_PORTS-1:0]                         in_ready,
    output logic [N_PORTS-1:0]                         out_valid,
    output logic [(2*ADDR_W+PAYLOAD_W)-1:0]            out_frame,
    output logic [7:0]                                 drop_cnt,
    output logic                                       table_full
);

    localparam int FRAME_W = 2*ADDR_W + PAYLOAD_W;
    localparam int PW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW      = PW + 1;
    localparam int TW      = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] BCAST = {ADDR_W{1'b1}};

    // stage 0: round-robin grant
    logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]       grant_idx;
    logic [CW-1:0]       rr_cand;
    logic                grant_found;
    logic [N_PORTS-1:0]  grant_oh;
    logic [FRAME_W-1:0]  grant_frame;

    // stage 1 registers
    logic                s1_valid_q, s1_valid_d;
    logic [FRAME_W-1:0]  s1_frame_q, s1_frame_d;
    logic [PW-1:0]       s1_port_q, s1_port_d;

    // learning table
    logic [TABLE_DEPTH-1:0] tbl_valid_q, tbl_valid_d;
    logic [ADDR_W-1:0]      tbl_addr_q [TABLE_DEPTH];
    logic [ADDR_W-1:0]      tbl_addr_d [TABLE_DEPTH];
    logic [PW-1:0]          tbl_port_q [TABLE_DEPTH];
    logic [PW-1:0]          tbl_port_d [TABLE_DEPTH];
    logic [TW-1:0]          repl_ptr_q, repl_ptr_d;

    // stage 1 combinational results
    logic [ADDR_W-1:0]   s1_dst, s1_src;
    logic                dst_hit, src_hit, free_found, learn_en, drop;
    logic [PW-1:0]       dst_port;
    logic [TW-1:0]       src_idx, free_idx, learn_idx;
    logic [N_PORTS-1:0]  ingress_oh, dst_oh, fwd_mask;

    // stage 2 registers
    logic [N_PORTS-1:0]  out_valid_q, out_valid_d;
    logic [FRAME_W-1:0]  out_frame_q, out_frame_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        rr_cand     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            rr_cand = {1'b0, rr_ptr_q} + CW'(k);
            if (rr_cand >= CW'(N_PORTS))
                rr_cand = rr_cand - CW'(N_PORTS);
            if (!grant_found && in_valid[rr_cand[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = rr_cand[PW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh    = '0;
        grant_frame = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (grant_idx == PW'(k)) begin
                grant_frame = in_frame[k*FRAME_W +: FRAME_W];
                grant_oh[k] = grant_found;
            end
        end
    end

    // grant is suppressed while reset is held so no source sees a false accept
    assign in_ready = FPGA_RST_BTN ? grant_oh : '0;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        s1_valid_d = grant_found;
        s1_frame_d = s1_frame_q;
        s1_port_d  = s1_port_q;
        if (grant_found) begin
            rr_ptr_d   = (grant_idx == PW'(N_PORTS-1)) ? '0 : grant_idx + PW'(1);
            s1_frame_d = grant_frame;
            s1_port_d  = grant_idx;
        end
    end

    assign s1_dst = s1_frame_q[FRAME_W-1 -: ADDR_W];
    assign s1_src = s1_frame_q[FRAME_W-ADDR_W-1 -: ADDR_W];

    always_comb begin
        dst_hit    = 1'b0;
        dst_port   = '0;
        src_hit    = 1'b0;
        src_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int e = 0; e < TABLE_DEPTH; e++) begin
            if (tbl_valid_q[e]) begin
                if (!dst_hit && tbl_addr_q[e] == s1_dst) begin
                    dst_hit  = 1'b1;
                    dst_port = tbl_port_q[e];
                end
                if (!src_hit && tbl_addr_q[e] == s1_src) begin
                    src_hit = 1'b1;
                    src_idx = TW'(e);
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = TW'(e);
            end
        end
    end

    always_comb begin
        ingress_oh = '0;
        dst_oh     = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            ingress_oh[k] = (s1_port_q == PW'(k));
            dst_oh[k]     = (dst_port == PW'(k));
        end
    end

    always_comb begin
        fwd_mask = '0;
        drop     = 1'b0;
        if (s1_valid_q) begin
            if (s1_dst == BCAST || !dst_hit)
                fwd_mask = ~ingress_oh;
            else if (dst_port == s1_port_q)
                drop = 1'b1;
            else
                fwd_mask = dst_oh;
        end
    end

    assign learn_en  = s1_valid_q && (s1_src != BCAST);
    assign learn_idx = src_hit ? src_idx : (free_found ? free_idx : repl_ptr_q);

`ifdef L2SW_AGING_EN
    localparam int ACW = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    logic [ACW-1:0] age_cnt_q, age_cnt_d;
    logic           age_tick;
    logic [1:0]     tbl_age_q [TABLE_DEPTH];
    logic [1:0]     tbl_age_d [TABLE_DEPTH];

    assign age_tick  = (age_cnt_q == '0);
    assign age_cnt_d = age_tick ? ACW'(AGE_PERIOD-1) : age_cnt_q - ACW'(1);

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
        if (!FPGA_RST_BTN) begin
            age_cnt_q <= ACW'(AGE_PERIOD-1);
            for (int e = 0; e < TABLE_DEPTH; e++)
                tbl_age_q[e] <= '0;
        end else begin
            age_cnt_q <= age_cnt_d;
            tbl_age_q <= tbl_age_d;
        end
    end
`else
    // the aging period is only meaningful when aging is compiled in
    logic unused_age_cfg;
    assign unused_age_cfg = ^AGE_PERIOD;
`endif

    always_comb begin
        tbl_valid_d = tbl_valid_q;
        tbl_addr_d  = tbl_addr_q;
        tbl_port_d  = tbl_port_q;
        repl_ptr_d  = repl_ptr_q;
`ifdef L2SW_AGING_EN
        tbl_age_d   = tbl_age_q;
        if (age_tick) begin
            for (int e = 0; e < TABLE_DEPTH; e++) begin
                if (tbl_valid_q[e]) begin
                    if (tbl_age_q[e] == 2'd2) begin
                        tbl_valid_d[e] = 1'b0;
                        tbl_age_d[e]   = 2'd0;
                    end else begin
                        tbl_age_d[e] = tbl_age_q[e] + 2'd1;
                    end
                end
            end
        end
`endif
        // learn is applied after aging so a same-cycle refresh wins
        if (learn_en) begin
            tbl_valid_d[learn_idx] = 1'b1;
            tbl_addr_d[learn_idx]  = s1_src;
            tbl_port_d[learn_idx]  = s1_port_q;
`ifdef L2SW_AGING_EN
            tbl_age_d[learn_idx]   = 2'd0;
`endif
            if (!src_hit && !free_found)
                repl_ptr_d = (repl_ptr_q == TW'(TABLE_DEPTH-1)) ? '0 : repl_ptr_q + TW'(1);
        end
    end

    always_comb begin
        out_valid_d = fwd_mask;
        out_frame_d = (|fwd_mask) ? s1_frame_q : out_frame_q;
        drop_cnt_d  = drop_cnt_q;
        if (drop && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_BTN) begin
        if (!FPGA_RST_BTN) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_frame_q  <= '0;
            s1_port_q   <= '0;
            tbl_valid_q <= '0;
            repl_ptr_q  <= '0;
            for (int e = 0; e < TABLE_DEPTH; e++) begin
                tbl_addr_q[e] <= '0;
                tbl_port_q[e] <= '0;
            end
            out_valid_q <= '0;
            out_frame_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_frame_q  <= s1_frame_d;
            s1_port_q   <= s1_port_d;
            tbl_valid_q <= tbl_valid_d;
            tbl_addr_q  <= tbl_addr_d;
            tbl_port_q  <= tbl_port_d;
            repl_ptr_q  <= repl_ptr_d;
            out_valid_q <= out_valid_d;
            out_frame_q <= out_frame_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_frame  = out_frame_q;
    assign drop_cnt   = drop_cnt_q;
    assign table_full = &tbl_valid_q;

endmodule

// File: tb/tb_l2_switch_fabric.sv
// Scoreboard bench for l2_switch_fabric: directed frames, expected egress queued, monitor compares.
module tb_l2_switch_fabric;

    localparam int N  = 4;
    localparam int FW = 12;
`ifdef L2SW_AGING_EN
    localparam int          AGE_P        = 16;
    localparam logic [15:0] EXP_FULL_AGE = 16'h0000;
    localparam logic [3:0]  EXP_AGE_MASK = 4'b1101;
`else
    localparam int          AGE_P        = 1024;
    localparam logic [15:0] EXP_FULL_AGE = 16'h0001;
    localparam logic [3:0]  EXP_AGE_MASK = 4'b0001;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*FW-1:0] in_frame;
    logic [N-1:0]    in_ready;
    logic [N-1:0]    out_valid;
    logic [FW-1:0]   out_frame;
    logic [7:0]      drop_cnt;
    logic            table_full;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] mon_e;

    always #5 clk = ~clk;

    l2_switch_fabric #(
        .N_PORTS(4), .ADDR_W(4), .PAYLOAD_W(4), .TABLE_DEPTH(4), .AGE_PERIOD(AGE_P)
    ) dut (
        .FPGA_CLK(clk), .FPGA_RST_BTN(rst_n),
        .in_valid(in_valid), .in_frame(in_frame), .in_ready(in_ready),
        .out_valid(out_valid), .out_frame(out_frame),
        .drop_cnt(drop_cnt), .table_full(table_full)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (out_valid !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual=%b/%h required=no output", out_valid, out_frame);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_mask", {12'h0, out_valid}, {12'h0, mon_e[15:12]});
                check("out_frame", {4'h0, out_frame}, {4'h0, mon_e[11:0]});
            end
        end
    end

    task automatic cycle(input string name, input logic [3:0] vmask,
                         input logic [11:0] f0, input logic [11:0] f1,
                         input logic [11:0] f2, input logic [11:0] f3,
                         input logic [3:0] exp_ready, input logic [3:0] exp_mask);
        logic [11:0] gf;
        @(negedge clk);
        in_valid = vmask;
        in_frame = {f3, f2, f1, f0};
        #1;
        check(name, {12'h0, in_ready}, {12'h0, exp_ready});
        gf = exp_ready[0] ? f0 : exp_ready[1] ? f1 : exp_ready[2] ? f2 : f3;
        if (exp_mask != 4'b0000)
            exp_q.push_back({exp_mask, gf});
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = '0;
        in_frame = '0;
        repeat (4) begin
            @(negedge clk);
            in_valid = 4'($urandom);
            in_frame = 48'({$urandom, $urandom});
            #1;
            check("rst_in_ready", {12'h0, in_ready}, 16'h0);
            check("rst_out_valid", {12'h0, out_valid}, 16'h0);
        end
        check("rst_drop_cnt", {8'h0, drop_cnt}, 16'h0);
        check("rst_table_full", {15'h0, table_full}, 16'h0);
        check("rst_out_frame", {4'h0, out_frame}, 16'h0);
        @(negedge clk);
        in_valid = '0;
        rst_n    = 1'b1;
        idle(5);

        // flood on miss, then learned unicast both ways
        cycle("flood_ready", 4'b0001, 12'hCA5, 12'h0, 12'h0, 12'h0, 4'b0001, 4'b1110);
        cycle("uni_ready_p2", 4'b0100, 12'h0, 12'h0, 12'hAC3, 12'h0, 4'b0100, 4'b0001);
        cycle("uni_ready_p0", 4'b0001, 12'hCA7, 12'h0, 12'h0, 12'h0, 4'b0001, 4'b0100);

        // round-robin from rr_ptr=1 with held requests
        cycle("rr_1", 4'b1010, 12'h0, 12'hA10, 12'h0, 12'hA30, 4'b0010, 4'b0001);
        cycle("rr_2", 4'b1010, 12'h0, 12'hA11, 12'h0, 12'hA30, 4'b1000, 4'b0001);
        cycle("rr_3", 4'b0011, 12'h1A2, 12'hA11, 12'h0, 12'h0, 4'b0001, 4'b0010);
        cycle("rr_4", 4'b0011, 12'h3A4, 12'hA11, 12'h0, 12'h0, 4'b0010, 4'b0001);
        cycle("rr_5", 4'b0001, 12'h3A4, 12'h0, 12'h0, 12'h0, 4'b0001, 4'b1000);

        // drop back to ingress, then broadcast
        cycle("drop_ready", 4'b0001, 12'hA05, 12'h0, 12'h0, 12'h0, 4'b0001, 4'b0000);
        idle(2);
        check("drop_cnt_1", {8'h0, drop_cnt}, 16'h0001);
        cycle("bcast_ready", 4'b0010, 12'h0, 12'hF13, 12'h0, 12'h0, 4'b0010, 4'b1101);
        idle(3);
        check("drop_cnt_hold", {8'h0, drop_cnt}, 16'h0001);

        // reset with a frame in flight: it must never reach egress
        cycle("rst_mid_ready", 4'b0010, 12'h0, 12'hC15, 12'h0, 12'h0, 4'b0010, 4'b0000);
        #1;
        rst_n = 1'b0;
        idle(2);
        in_valid = 4'b1111;
        #1;
        check("rst_mid_in_ready", {12'h0, in_ready}, 16'h0);
        check("rst_mid_out_valid", {12'h0, out_valid}, 16'h0);
        check("rst_mid_drop_cnt", {8'h0, drop_cnt}, 16'h0);
        check("rst_mid_table_full", {15'h0, table_full}, 16'h0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // fill the table, then replacement at repl_ptr
        cycle("fill_1", 4'b0010, 12'h0, 12'h910, 12'h0, 12'h0, 4'b0010, 4'b1101);
        cycle("fill_2", 4'b0010, 12'h0, 12'h920, 12'h0, 12'h0, 4'b0010, 4'b1101);
        cycle("fill_3", 4'b0010, 12'h0, 12'h930, 12'h0, 12'h0, 4'b0010, 4'b1101);
        cycle("fill_4", 4'b0010, 12'h0, 12'h940, 12'h0, 12'h0, 4'b0010, 4'b1101);
        idle(2);
        check("table_full_1", {15'h0, table_full}, 16'h0001);
        cycle("repl_src5", 4'b0100, 12'h0, 12'h0, 12'h950, 12'h0, 4'b0100, 4'b1011);
        cycle("learn_vis", 4'b1000, 12'h0, 12'h0, 12'h0, 12'h5B6, 4'b1000, 4'b0100);
        cycle("evicted", 4'b0001, 12'h1C7, 12'h0, 12'h0, 12'h0, 4'b0001, 4'b1110);
        cycle("kept", 4'b0001, 12'h4D8, 12'h0, 12'h0, 12'h0, 4'b0001, 4'b0010);
        cycle("self_miss", 4'b1000, 12'h0, 12'h0, 12'h0, 12'hEE9, 4'b1000, 4'b0111);
        idle(3);
        check("drop_cnt_zero", {8'h0, drop_cnt}, 16'h0);

        // long idle: aged-out table floods, persistent table still unicasts
        idle(64);
        check("age_table_full", {15'h0, table_full}, EXP_FULL_AGE);
        cycle("age_lookup", 4'b0010, 12'h0, 12'hD1A, 12'h0, 12'h0, 4'b0010, EXP_AGE_MASK);
        idle(4);
        check("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
